// File: rtl/sdc_dma_split.sv
// sdc_dma_split: splits upstream 32-bit INCR bursts (up to 256 beats) into
// sub-bursts that never cross a blk-byte cache-block boundary. Read and write
// paths are independent; each carries one upstream burst and one downstream
// sub-burst at a time. Data channels are combinational pass-through.
module sdc_dma_split #(
  parameter int blk = 64
) (
  input  logic        clk,
  input  logic        rst,
  // upstream write
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  // upstream read
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  // downstream write
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  // downstream read
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int BPB = blk / 4;
  localparam int LB  = $clog2(blk);
  localparam int OW  = LB - 2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_st_t;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_BOUT} wr_st_t;

  // beats to the next block boundary, clipped to what is left of the burst
  function automatic logic [8:0] sub_beats(input logic [OW-1:0] off, input logic [8:0] rem);
    logic [8:0] room;
    room = 9'(BPB) - 9'(off);
    return (rem < room) ? rem : room;
  endfunction

  // upstream wlast carries no information: sub-burst ends come from cnt
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  assign m_axi_arsize  = 3'd2;
  assign m_axi_arburst = 2'd1;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'd1;

  // ---------------- read path ----------------
  rd_st_t      r_state, r_next;
  logic [31:0] r_addr;
  logic [8:0]  r_rem, r_beats;
  logic        r_last_hs, r_fin;

  assign r_beats     = sub_beats(r_addr[LB-1:2], r_rem);
  assign r_fin       = (r_rem == r_beats);
  assign r_last_hs   = (r_state == R_DATA) & m_axi_rvalid & s_axi_rready & m_axi_rlast;
  assign m_axi_araddr = r_addr;
  assign m_axi_arlen  = 8'(r_beats - 9'd1);
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;

  // read state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;

  // read next-state
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (s_axi_arvalid) r_next = R_AR;
      R_AR:    if (m_axi_arready) r_next = R_DATA;
      R_DATA:  if (r_last_hs)     r_next = r_fin ? R_IDLE : R_AR;
      default: r_next = R_IDLE;
    endcase
  end

  // read outputs: R channel only connected while a sub-burst is open
  always_comb begin
    s_axi_arready = (r_state == R_IDLE);
    m_axi_arvalid = (r_state == R_AR);
    s_axi_rvalid  = (r_state == R_DATA) & m_axi_rvalid;
    m_axi_rready  = (r_state == R_DATA) & s_axi_rready;
    s_axi_rlast   = (r_state == R_DATA) & m_axi_rlast & r_fin;
  end

  // read address/remaining bookkeeping, advanced at each sub-burst end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (r_state == R_IDLE && s_axi_arvalid) begin
      r_addr <= s_axi_araddr;
      r_rem  <= 9'(s_axi_arlen) + 9'd1;
    end else if (r_last_hs) begin
      r_addr <= r_addr + {21'd0, r_beats, 2'b00};
      r_rem  <= r_rem - r_beats;
    end

  // ---------------- write path ----------------
  wr_st_t      w_state, w_next;
  logic [31:0] w_addr;
  logic [8:0]  w_rem, w_cnt, w_beats;
  logic [1:0]  w_err;
  logic        w_beat_hs, w_b_hs;

  assign w_beats      = sub_beats(w_addr[LB-1:2], w_rem);
  assign w_beat_hs    = (w_state == W_DATA) & s_axi_wvalid & m_axi_wready;
  assign w_b_hs       = (w_state == W_RESP) & m_axi_bvalid;
  assign m_axi_awaddr = w_addr;
  assign m_axi_awlen  = 8'(w_beats - 9'd1);
  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign s_axi_bresp  = w_err;

  // write state register
  always_ff @(posedge clk or posedge rst)
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;

  // write next-state
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (s_axi_awvalid) w_next = W_AW;
      W_AW:    if (m_axi_awready) w_next = W_DATA;
      W_DATA:  if (w_beat_hs && w_cnt == 9'd1) w_next = W_RESP;
      W_RESP:  if (m_axi_bvalid) w_next = (w_rem == 9'd0) ? W_BOUT : W_AW;
      W_BOUT:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // write outputs: W gated to DATA so beats never run ahead of their AW
  always_comb begin
    s_axi_awready = (w_state == W_IDLE);
    m_axi_awvalid = (w_state == W_AW);
    m_axi_wvalid  = (w_state == W_DATA) & s_axi_wvalid;
    s_axi_wready  = (w_state == W_DATA) & m_axi_wready;
    m_axi_wlast   = (w_state == W_DATA) & (w_cnt == 9'd1);
    m_axi_bready  = (w_state == W_RESP);
    s_axi_bvalid  = (w_state == W_BOUT);
  end

  // write bookkeeping: beat counter, address/remaining, worst response seen
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_addr <= '0;
      w_rem  <= '0;
      w_cnt  <= '0;
      w_err  <= '0;
    end else begin
      if (w_state == W_IDLE && s_axi_awvalid) begin
        w_addr <= s_axi_awaddr;
        w_rem  <= 9'(s_axi_awlen) + 9'd1;
        w_err  <= '0;
      end
      if (w_state == W_AW && m_axi_awready) w_cnt <= w_beats;
      if (w_beat_hs) begin
        w_cnt <= w_cnt - 9'd1;
        if (w_cnt == 9'd1) begin
          w_addr <= w_addr + {21'd0, w_beats, 2'b00};
          w_rem  <= w_rem - w_beats;
        end
      end
      if (w_b_hs && m_axi_bresp > w_err) w_err <= m_axi_bresp;
    end

endmodule

// File: tb/tb_sdc_dma_split.sv
// Directed bench for sdc_dma_split (blk = 64): a small downstream slave model
// answers AR/R/AW/W/B, logs every handshake, and the main sequence compares
// those logs against hand-computed sub-burst splits.
`timescale 1ns/1ps
module tb_sdc_dma_split;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  sdc_dma_split #(.blk(64)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- downstream slave model + monitors ----------------
  bit          stall = 0;
  logic [39:0] ar_q[$], ar_log[$], aw_log[$], r_cur;
  logic [32:0] w_log[$], r_log[$];
  logic [1:0]  b_log[$], bresp_q[$];
  int          b_mcnt_log[$];
  logic [3:0]  wstrb_last;
  int          m_b_cnt = 0, pend_b = 0, r_beat = 0;
  bit          r_act = 0, ar_hs, r_hs, aw_hs, w_hs, b_hs;

  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; s_axi_rready = 0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid & m_axi_arready;
      r_hs  = m_axi_rvalid & m_axi_rready;
      aw_hs = m_axi_awvalid & m_axi_awready;
      w_hs  = m_axi_wvalid & m_axi_wready;
      b_hs  = m_axi_bvalid & m_axi_bready;
      if (ar_hs) begin ar_q.push_back({m_axi_arlen, m_axi_araddr}); ar_log.push_back({m_axi_arlen, m_axi_araddr}); end
      if (aw_hs) aw_log.push_back({m_axi_awlen, m_axi_awaddr});
      if (w_hs) begin
        w_log.push_back({m_axi_wlast, m_axi_wdata});
        wstrb_last = m_axi_wstrb;
        if (m_axi_wlast) pend_b++;
      end
      if (b_hs) m_b_cnt++;
      if (s_axi_rvalid & s_axi_rready) r_log.push_back({s_axi_rlast, s_axi_rdata});
      if (s_axi_bvalid & s_axi_bready) begin b_log.push_back(s_axi_bresp); b_mcnt_log.push_back(m_b_cnt); end
      @(posedge clk); #1;
      if (rst) begin
        ar_q.delete(); r_act = 0; pend_b = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        continue;
      end
      m_axi_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axi_rready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r_hs) begin
        if (r_beat == int'(r_cur[39:32])) r_act = 0;
        else r_beat++;
      end
      if (!r_act && ar_q.size() > 0) begin r_cur = ar_q.pop_front(); r_beat = 0; r_act = 1; end
      if (!(m_axi_rvalid && !r_hs)) begin
        m_axi_rvalid = r_act && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
        m_axi_rdata  = r_cur[31:0] + 32'(r_beat * 4);
        m_axi_rlast  = (r_beat == int'(r_cur[39:32]));
      end
      if (b_hs) pend_b--;
      if (!(m_axi_bvalid && !b_hs)) begin
        m_axi_bvalid = (pend_b > 0);
        if (m_axi_bvalid) m_axi_bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'd0;
      end
    end
  end

  // ---------------- upstream helpers ----------------
  task automatic clear_logs();
    ar_log.delete(); aw_log.delete(); w_log.delete(); r_log.delete();
    b_log.delete(); b_mcnt_log.delete(); m_b_cnt = 0;
  endtask

  task automatic send_w(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      s_axi_wvalid = 1; s_axi_wdata = base + 32'(i); s_axi_wstrb = 4'(i);
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (s_axi_wready || rst) break;
      end
      @(posedge clk); #1;
      if (rst) break;
    end
    s_axi_wvalid = 0;
  endtask

  task automatic issue_aw(input logic [31:0] a, input logic [7:0] l);
    s_axi_awaddr = a; s_axi_awlen = l; s_axi_awvalid = 1;
    @(negedge clk); chk("awready_idle", s_axi_awready, 1);
    @(posedge clk); #1; s_axi_awvalid = 0;
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [7:0] l);
    s_axi_araddr = a; s_axi_arlen = l; s_axi_arvalid = 1;
    @(negedge clk); chk("arready_idle", s_axi_arready, 1);
    @(posedge clk); #1; s_axi_arvalid = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_wlast = 0; s_axi_wvalid = 0; s_axi_bready = 1; s_axi_araddr = 0; s_axi_arlen = 0;
    s_axi_arvalid = 0;
    #1;
    chk("rst_readies", {s_axi_arready, s_axi_awready}, 2'b11);
    chk("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, s_axi_rvalid}, 5'b0);
    chk("rst_readies_dn", {m_axi_rready, m_axi_bready}, 2'b0);
    chk("rst_lasts", {m_axi_wlast, s_axi_rlast}, 2'b0);
    chk("consts", {m_axi_arsize, m_axi_arburst, m_axi_awsize, m_axi_awburst}, {3'd2, 2'd1, 3'd2, 2'd1});
    repeat (3) @(posedge clk); #1; rst = 0;
    repeat (2) @(posedge clk); #1;

    // aligned read: one sub-burst
    clear_logs();
    issue_ar(32'h1000, 8'd15);
    @(negedge clk); chk("t1_arvalid_lat", {m_axi_arvalid, m_axi_arlen, m_axi_araddr}, {1'b1, 8'd15, 32'h1000});
    for (int c = 0; c < 1000 && r_log.size() < 16; c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    chk("t1_ar_n", ar_log.size(), 1);
    chk("t1_ar0", ar_log[0], {8'd15, 32'h1000});
    chk("t1_r_n", r_log.size(), 16);
    for (int i = 0; i < 16; i++) chk("t1_r", r_log[i], {(i == 15), 32'h1000 + 32'(4 * i)});
    chk("t1_idle", s_axi_arready, 1);

    // unaligned read: 2 + 6 beats across 0x1040
    clear_logs();
    issue_ar(32'h1038, 8'd7);
    for (int c = 0; c < 1000 && r_log.size() < 8; c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    chk("t2_ar_n", ar_log.size(), 2);
    chk("t2_ar0", ar_log[0], {8'd1, 32'h1038});
    chk("t2_ar1", ar_log[1], {8'd5, 32'h1040});
    chk("t2_r_n", r_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_r", r_log[i], {(i == 7), 32'h1038 + 32'(4 * i)});

    // max write: 256 beats -> 16 sub-bursts of 16
    clear_logs();
    issue_aw(32'h2000, 8'd255);
    @(negedge clk); chk("t3_awvalid_lat", {m_axi_awvalid, m_axi_awlen, m_axi_awaddr}, {1'b1, 8'd15, 32'h2000});
    send_w(256, 32'hA000_0000);
    for (int c = 0; c < 1000 && b_log.size() < 1; c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    chk("t3_aw_n", aw_log.size(), 16);
    for (int k = 0; k < 16; k++) chk("t3_aw", aw_log[k], {8'd15, 32'h2000 + 32'(64 * k)});
    chk("t3_w_n", w_log.size(), 256);
    for (int i = 0; i < 256; i++) chk("t3_w", w_log[i], {(i % 16 == 15), 32'hA000_0000 + 32'(i)});
    chk("t3_strb", wstrb_last, 4'hF);
    chk("t3_b_n", b_log.size(), 1);
    chk("t3_b", b_log[0], 2'd0);
    chk("t3_b_after", b_mcnt_log[0], 16);

    // error merge: third downstream B is SLVERR
    clear_logs();
    bresp_q = '{2'd0, 2'd0, 2'd2, 2'd0};
    issue_aw(32'h3000, 8'd63);
    send_w(64, 32'hC000_0000);
    for (int c = 0; c < 1000 && b_log.size() < 1; c++) @(posedge clk);
    repeat (5) @(posedge clk); #1;
    chk("t4_aw_n", aw_log.size(), 4);
    chk("t4_b_n", b_log.size(), 1);
    chk("t4_b", b_log[0], 2'd2);
    chk("t4_b_after", b_mcnt_log[0], 4);

    // concurrent read and write under random backpressure
    clear_logs();
    stall = 1;
    s_axi_araddr = 32'h4010; s_axi_arlen = 8'd40; s_axi_arvalid = 1;
    s_axi_awaddr = 32'h5020; s_axi_awlen = 8'd20; s_axi_awvalid = 1;
    @(negedge clk); chk("t5_both_ready", {s_axi_arready, s_axi_awready}, 2'b11);
    @(posedge clk); #1; s_axi_arvalid = 0; s_axi_awvalid = 0;
    fork
      send_w(21, 32'hB000_0000);
      for (int c = 0; c < 3000 && r_log.size() < 41; c++) @(posedge clk);
    join
    for (int c = 0; c < 1000 && b_log.size() < 1; c++) @(posedge clk);
    stall = 0;
    repeat (5) @(posedge clk); #1;
    chk("t5_ar_n", ar_log.size(), 3);
    chk("t5_ar0", ar_log[0], {8'd11, 32'h4010});
    chk("t5_ar1", ar_log[1], {8'd15, 32'h4040});
    chk("t5_ar2", ar_log[2], {8'd12, 32'h4080});
    chk("t5_r_n", r_log.size(), 41);
    for (int i = 0; i < 41; i++) chk("t5_r", r_log[i], {(i == 40), 32'h4010 + 32'(4 * i)});
    chk("t5_aw_n", aw_log.size(), 2);
    chk("t5_aw0", aw_log[0], {8'd7, 32'h5020});
    chk("t5_aw1", aw_log[1], {8'd12, 32'h5040});
    chk("t5_w_n", w_log.size(), 21);
    for (int i = 0; i < 21; i++) chk("t5_w", w_log[i], {(i == 7 || i == 20), 32'hB000_0000 + 32'(i)});
    chk("t5_b_n", b_log.size(), 1);
    chk("t5_b", b_log[0], 2'd0);

    // reset during the second sub-burst of a write
    clear_logs();
    issue_aw(32'h6000, 8'd31);
    send_w(20, 32'hD000_0000);
    chk("t6_aw_n", aw_log.size(), 2);
    @(posedge clk); #3; rst = 1; #1;
    chk("t6_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, s_axi_rvalid}, 5'b0);
    chk("t6_rdy_dn", {m_axi_rready, m_axi_bready, m_axi_wlast}, 3'b0);
    chk("t6_readies", {s_axi_awready, s_axi_arready}, 2'b11);
    repeat (2) @(posedge clk); #1; rst = 0;
    repeat (3) @(posedge clk); #1;
    chk("t6_no_b", b_log.size(), 0);
    clear_logs();
    issue_aw(32'h7000, 8'd3);
    send_w(4, 32'hE000_0000);
    for (int c = 0; c < 500 && b_log.size() < 1; c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    chk("t6_aw_n2", aw_log.size(), 1);
    chk("t6_aw", aw_log[0], {8'd3, 32'h7000});
    chk("t6_w_n", w_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6_w", w_log[i], {(i == 3), 32'hE000_0000 + 32'(i)});
    chk("t6_b_n", b_log.size(), 1);
    chk("t6_b", b_log[0], 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdc_dma_split.md
# sdc_dma_split

Burst splitter on the SD-card DMA path, between the SD controller wrapper's AXI master port and the memory interconnect. It takes 32-bit INCR read and write bursts of up to 256 beats and reissues each one as a sequence of sub-bursts that never cross a `blk`-byte cache-block boundary. Block-granular coherence ownership therefore maps one-to-one onto downstream transactions. Read data, last flags and write responses are merged so the upstream side sees exactly one burst.

## Interface
- `blk`, default 64: cache block size in bytes; power of two, 8..1024.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `s_axi_awaddr`  in  32: upstream write address, 4-byte aligned.
- `s_axi_awlen`  in  8: upstream write length, beats minus 1.
- `s_axi_awvalid`/`s_axi_awready`  in/out  1: upstream AW handshake.
- `s_axi_wdata`  in  32, `s_axi_wstrb`  in  4, `s_axi_wlast`  in  1: upstream W payload; `s_axi_wlast` is ignored.
- `s_axi_wvalid`/`s_axi_wready`  in/out  1: upstream W handshake.
- `s_axi_bresp`  out  2, `s_axi_bvalid`/`s_axi_bready`  out/in  1: merged write response.
- `s_axi_araddr`  in  32, `s_axi_arlen`  in  8, `s_axi_arvalid`/`s_axi_arready`  in/out  1: upstream read request.
- `s_axi_rdata`  out  32, `s_axi_rresp`  out  2, `s_axi_rlast`  out  1, `s_axi_rvalid`/`s_axi_rready`  out/in  1: upstream read data.
- `m_axi_aw{addr,len,size,burst,valid,ready}`  out/out/out/out/out/in  32/8/3/2/1/1: downstream AW.
- `m_axi_w{data,strb,last,valid,ready}`  out/out/out/out/in  32/4/1/1/1: downstream W.
- `m_axi_b{resp,valid,ready}`  in/in/out  2/1/1: downstream B.
- `m_axi_ar{addr,len,size,burst,valid,ready}`  out/out/out/out/out/in  32/8/3/2/1/1: downstream AR.
- `m_axi_r{data,resp,last,valid,ready}`  in/in/in/in/out  32/2/1/1/1: downstream R.

## Operation
- Constants: `m_axi_*size` = 2; `m_axi_*burst` = 1 (INCR). BPB = `blk`/4 beats per block.
- Read and write paths are independent. Each path allows one upstream burst and one downstream sub-burst in flight.
- Per-path registers:
  - `addr` (32 bits).
  - `rem` (9 bits): beats remaining, loaded with len+1, range 1..256.
  - `cnt` (9 bits): beats left in the current sub-burst.
- Sub-burst length: beats = min(`rem`, BPB − `addr`[log2(blk)−1:2]); `len` = beats − 1.
- After each sub-burst: `addr` += beats×4, modulo 2^32. `rem` −= beats.
- Read FSM, states IDLE, AR, DATA:
  - IDLE: `s_axi_arready` = 1. On handshake, load `addr`/`rem` and go to AR.
  - AR: `m_axi_arvalid` = 1 with computed addr/len. On `m_axi_arready`, load `cnt` and go to DATA.
  - DATA: combinational pass-through. `s_axi_rvalid` = `m_axi_rvalid`, `m_axi_rready` = `s_axi_rready`; data and resp are passed unchanged.
  - `s_axi_rlast` = `m_axi_rlast` & (`rem` − beats == 0).
  - On a downstream last-beat handshake: if `rem` becomes 0, go to IDLE; otherwise go to AR.
- Write FSM, states IDLE, AW, DATA, RESP, BOUT:
  - IDLE: `s_axi_awready` = 1. On handshake, load registers, clear `err`, go to AW.
  - AW: issue the sub-burst as for AR, then go to DATA.
  - DATA: W passes through combinationally. `m_axi_wlast` = (`cnt` == 1); `cnt` decrements per beat. After the final sub-burst beat, go to RESP.
  - RESP: `m_axi_bready` = 1. On B, `err` = max(`err`, `bresp`). If `rem` == 0, go to BOUT; otherwise go to AW.
  - BOUT: `s_axi_bvalid` = 1 and `s_axi_bresp` = `err`. On `s_axi_bready`, go to IDLE.
- W beats are not accepted outside DATA: `s_axi_wready` = `m_axi_wready` & (state == DATA).

## Timing
- Reset, asynchronous: both FSMs go to IDLE immediately and all counters clear.
  - `s_axi_arready` = `s_axi_awready` = 1.
  - Every `*valid` output, `m_axi_rready` and `m_axi_bready` = 0.
  - `m_axi_wlast` = 0 and `s_axi_rlast` = 0.
  - A transaction in flight is dropped with no response.
- Request latency: upstream AR/AW handshake in cycle N puts `m_axi_arvalid`/`awvalid` high in cycle N+1. Next sub-burst request is valid the cycle after the previous last beat (read) or B handshake (write).
- Data channels have zero added latency. Ready/valid are combinational pass-through; no buffering.
- Merged B is valid one cycle after the final downstream B.
- `m_axi_*valid` holds stable with payload until ready, per AXI.
- Boundary: a length-256 burst at block-aligned `addr` gives exactly 1024/`blk` sub-bursts. `rem` = 256 fits in 9 bits.
- Simultaneous upstream AR and AW in the same cycle are both accepted.

## Test plan
- Aligned read, `blk` = 64: araddr 0x1000, arlen 15 → one AR 0x1000 len 15; 16 R beats pass through; `s_axi_rlast` only on beat 16.
- Unaligned read: araddr 0x1038, arlen 7 → AR 0x1038 len 1, then AR 0x1040 len 5; 8 upstream beats with `rlast` on the 8th only.
- Max write: awaddr 0x2000, awlen 255 → 16 AWs (0x2000..0x23C0, len 15); `wlast` on every 16th beat; one upstream B, OKAY.
- Error merge: 3rd of 4 sub-burst Bs returns SLVERR (2) → `s_axi_bresp` = 2, issued once after the 4th B.
- Concurrency/backpressure: AR and AW in the same cycle with random `m_*ready`/`s_rready` stalls → both complete; data order and counts are correct.
- Reset mid-write: assert `rst` during the 2nd sub-burst → all valids 0 at once, `awready` = 1; a fresh burst after release completes normally.
